// File: rtl/cp0_intc_if.sv
// Bus between the M stage and the CP0 interrupt controller: mtc0/mfc0 access,
// exception inputs from the pipeline, and the entry/EPC outputs back to it.
interface cp0_intc_if #(
    parameter int NUM_HWINT = 6
);
    logic                 we;
    logic [4:0]           addr_rd;
    logic [4:0]           addr_wr;
    logic [31:0]          din;
    logic [31:0]          pc_in;
    logic                 bd_in;
    logic [4:0]           exc_code_in;
    logic                 exl_clr;
    logic [NUM_HWINT-1:0] hw_int;
    logic [31:0]          dout;
    logic [31:0]          epc;
    logic                 int_req;
    logic                 exc_is_int;

    modport master (
        output we, addr_rd, addr_wr, din, pc_in, bd_in, exc_code_in, exl_clr, hw_int,
        input  dout, epc, int_req, exc_is_int
    );

    modport slave (
        input  we, addr_rd, addr_wr, din, pc_in, bd_in, exc_code_in, exl_clr, hw_int,
        output dout, epc, int_req, exc_is_int
    );
endinterface

// File: rtl/cp0_intc.sv
// Coprocessor-0 interrupt controller: SR/Cause/EPC/PRId plus optional Count/Compare,
// decides exception or interrupt entry at the M stage and serves mfc0/mtc0.
module cp0_intc #(
    parameter int          NUM_HWINT  = 6,
    parameter int          INT_EDGE   = 0,
    parameter int          TIMER_EN   = 0,
    parameter logic [31:0] PRID_VALUE = 32'h2017_1204
) (
    input logic        clk,
    input logic        reset,
    cp0_intc_if.slave  bus
);
    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_SR      = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;
    localparam logic [4:0] ADDR_PRID    = 5'd15;

    logic [7:0]           im;
    logic                 exl;
    logic                 ie;
    logic                 bdReg;
    logic [4:0]           excCode;
    logic [1:0]           swIp;
    logic [NUM_HWINT-1:0] hwReg;
    logic [NUM_HWINT-1:0] hwIp;
    logic [31:0]          epcReg;
    logic [31:0]          count;
    logic [31:0]          compare;
    logic                 timerPend;

    logic [7:0]  ip;
    logic        pend;
    logic        intReq;
    logic        wrEn;
    logic        wrSr;
    logic        wrCause;
    logic        wrEpc;
    logic        wrCount;
    logic        wrCompare;
    logic [31:0] pcAdj;
    logic [31:0] countInc;

    // ip[k] is Cause.IP[8+k]: two software bits, the hardware lines, then the timer on top.
    always_comb begin
        ip = 8'h00;
        ip[1:0] = swIp;
        for (int i = 0; i < NUM_HWINT; i++) begin
            ip[2+i] = hwIp[i];
        end
        if (TIMER_EN != 0) begin
            ip[7] = timerPend;
        end
    end

    assign pend   = ie & ~exl & (|(ip & im));
    assign intReq = pend | (bus.exc_code_in != 5'd0);

    assign bus.int_req    = reset & intReq;
    assign bus.exc_is_int = reset & pend;
    assign bus.epc        = epcReg;

    // Entry owns the edge, so any mtc0 issued alongside it is dropped.
    assign wrEn      = bus.we & ~intReq;
    assign wrSr      = wrEn && (bus.addr_wr == ADDR_SR);
    assign wrCause   = wrEn && (bus.addr_wr == ADDR_CAUSE);
    assign wrEpc     = wrEn && (bus.addr_wr == ADDR_EPC);
    assign wrCount   = wrEn && (bus.addr_wr == ADDR_COUNT);
    assign wrCompare = wrEn && (bus.addr_wr == ADDR_COMPARE);

    assign pcAdj    = bus.bd_in ? (bus.pc_in - 32'd4) : bus.pc_in;
    assign countInc = count + 32'd1;

    // SR, Cause.BD/ExcCode and EPC: entry beats eret, and eret beats an SR write to EXL.
    always_ff @(posedge clk) begin
        if (!reset) begin
            im      <= 8'h00;
            exl     <= 1'b0;
            ie      <= 1'b0;
            bdReg   <= 1'b0;
            excCode <= 5'd0;
            epcReg  <= 32'h0;
        end else if (intReq) begin
            exl     <= 1'b1;
            excCode <= pend ? 5'd0 : bus.exc_code_in;
            bdReg   <= bus.bd_in;
            epcReg  <= {pcAdj[31:2], 2'b00};
        end else begin
            if (wrSr) begin
                im  <= bus.din[15:8];
                exl <= bus.din[1];
                ie  <= bus.din[0];
            end
            if (bus.exl_clr) begin
                exl <= 1'b0;
            end
            if (wrEpc) begin
                epcReg <= {bus.din[31:2], 2'b00};
            end
        end
    end

    // Software bits plus hardware lines; an edge arriving with a clearing write stays latched.
    always_ff @(posedge clk) begin
        if (!reset) begin
            swIp  <= 2'b00;
            hwReg <= '0;
            hwIp  <= '0;
        end else begin
            hwReg <= bus.hw_int;
            if (wrCause) begin
                swIp <= bus.din[9:8];
            end
            if (INT_EDGE == 0) begin
                hwIp <= bus.hw_int;
            end else begin
                hwIp <= (wrCause ? (hwIp & bus.din[10 +: NUM_HWINT]) : hwIp)
                        | (bus.hw_int & ~hwReg);
            end
        end
    end

    // Timer pending only sets on a real increment hitting Compare, never on a load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count     <= 32'h0;
            compare   <= 32'h0;
            timerPend <= 1'b0;
        end else if (TIMER_EN != 0) begin
            if (wrCount) begin
                count <= bus.din;
            end else begin
                count <= countInc;
            end
            if (wrCompare) begin
                compare   <= bus.din;
                timerPend <= 1'b0;
            end else if (!wrCount && (countInc == compare)) begin
                timerPend <= 1'b1;
            end
        end
    end

    // mfc0 returns pre-edge state; the pipeline forwards fresh writes itself.
    always_comb begin
        bus.dout = 32'h0;
        case (bus.addr_rd)
            ADDR_SR:      bus.dout = {16'h0, im, 6'b0, exl, ie};
            ADDR_CAUSE:   bus.dout = {bdReg, 15'h0, ip, 1'b0, excCode, 2'b00};
            ADDR_EPC:     bus.dout = epcReg;
            ADDR_PRID:    bus.dout = PRID_VALUE;
            ADDR_COUNT:   bus.dout = (TIMER_EN != 0) ? count : 32'h0;
            ADDR_COMPARE: bus.dout = (TIMER_EN != 0) ? compare : 32'h0;
            default:      bus.dout = 32'h0;
        endcase
    end
endmodule

// File: tb/tb_cp0_intc.sv
// Directed bench: dutA is a 6-line level-mode build, dutB a 5-line edge-mode build with the timer.
module tb_cp0_intc;
    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] rd;

    cp0_intc_if #(.NUM_HWINT(6)) busA ();
    cp0_intc_if #(.NUM_HWINT(5)) busB ();

    cp0_intc #(.NUM_HWINT(6), .INT_EDGE(0), .TIMER_EN(0)) dutA (
        .clk(clk), .reset(reset), .bus(busA)
    );
    cp0_intc #(.NUM_HWINT(5), .INT_EDGE(1), .TIMER_EN(1)) dutB (
        .clk(clk), .reset(reset), .bus(busB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every step lands 1 ns after the rising edge so outputs are settled when read.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wrA(input logic [4:0] a, input logic [31:0] d);
        busA.we = 1'b1; busA.addr_wr = a; busA.din = d;
        tick();
        busA.we = 1'b0;
    endtask

    task automatic wrB(input logic [4:0] a, input logic [31:0] d);
        busB.we = 1'b1; busB.addr_wr = a; busB.din = d;
        tick();
        busB.we = 1'b0;
    endtask

    task automatic rdA(input logic [4:0] a, output logic [31:0] d);
        busA.addr_rd = a;
        #1;
        d = busA.dout;
    endtask

    task automatic rdB(input logic [4:0] a, output logic [31:0] d);
        busB.addr_rd = a;
        #1;
        d = busB.dout;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (busA.int_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_intreq: got %b expected 0", busA.int_req); end
        rdA(5'd12, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL rst_sr: got %h expected 00000000", rd); end
        rdA(5'd15, rd);
        checks++; if (rd !== 32'h2017_1204) begin errors++; $display("[TB] FAIL rst_prid: got %h expected 20171204", rd); end
        rdB(5'd13, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL rst_cause_b: got %h expected 00000000", rd); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_level();
        wrA(5'd12, 32'h0000_FC01);
        rdA(5'd12, rd);
        checks++; if (rd !== 32'h0000_FC01) begin errors++; $display("[TB] FAIL lvl_sr: got %h expected 0000fc01", rd); end
        busA.pc_in = 32'h0000_1000;
        busA.hw_int = 6'b000100;
        #1;
        checks++; if (busA.int_req !== 1'b0) begin errors++; $display("[TB] FAIL lvl_latency: got %b expected 0", busA.int_req); end
        tick();
        checks++; if ({busA.int_req, busA.exc_is_int} !== 2'b11) begin errors++; $display("[TB] FAIL lvl_req: got %b expected 11", {busA.int_req, busA.exc_is_int}); end
        tick();
        rdA(5'd12, rd);
        checks++; if (rd !== 32'h0000_FC03) begin errors++; $display("[TB] FAIL lvl_exl: got %h expected 0000fc03", rd); end
        rdA(5'd13, rd);
        checks++; if (rd !== 32'h0000_1000) begin errors++; $display("[TB] FAIL lvl_cause: got %h expected 00001000", rd); end
        checks++; if (busA.epc !== 32'h0000_1000) begin errors++; $display("[TB] FAIL lvl_epc: got %h expected 00001000", busA.epc); end
        checks++; if (busA.int_req !== 1'b0) begin errors++; $display("[TB] FAIL lvl_masked: got %b expected 0", busA.int_req); end
        busA.hw_int = 6'b000000;
        tick();
    endtask

    task automatic test_sync_exc();
        busA.exc_code_in = 5'd12; busA.bd_in = 1'b1; busA.pc_in = 32'h0000_3010;
        #1;
        checks++; if ({busA.int_req, busA.exc_is_int} !== 2'b10) begin errors++; $display("[TB] FAIL exc_req: got %b expected 10", {busA.int_req, busA.exc_is_int}); end
        tick();
        busA.exc_code_in = 5'd0; busA.bd_in = 1'b0;
        rdA(5'd13, rd);
        checks++; if (rd !== 32'h8000_0030) begin errors++; $display("[TB] FAIL exc_cause: got %h expected 80000030", rd); end
        checks++; if (busA.epc !== 32'h0000_300C) begin errors++; $display("[TB] FAIL exc_epc_bd: got %h expected 0000300c", busA.epc); end
        busA.exl_clr = 1'b1; busA.exc_code_in = 5'd4; busA.pc_in = 32'h0000_4000;
        tick();
        busA.exl_clr = 1'b0; busA.exc_code_in = 5'd0;
        rdA(5'd12, rd);
        checks++; if (rd !== 32'h0000_FC03) begin errors++; $display("[TB] FAIL exc_over_eret: got %h expected 0000fc03", rd); end
        rdA(5'd13, rd);
        checks++; if (rd !== 32'h0000_0010) begin errors++; $display("[TB] FAIL exc_cause2: got %h expected 00000010", rd); end
        busA.exl_clr = 1'b1;
        tick();
        busA.exl_clr = 1'b0;
        rdA(5'd12, rd);
        checks++; if (rd !== 32'h0000_FC01) begin errors++; $display("[TB] FAIL eret: got %h expected 0000fc01", rd); end
    endtask

    task automatic test_softint();
        wrA(5'd13, 32'h0000_0200);
        checks++; if (busA.int_req !== 1'b0) begin errors++; $display("[TB] FAIL sw_unmasked: got %b expected 0", busA.int_req); end
        wrA(5'd12, 32'h0000_0201);
        checks++; if ({busA.int_req, busA.exc_is_int} !== 2'b11) begin errors++; $display("[TB] FAIL sw_req: got %b expected 11", {busA.int_req, busA.exc_is_int}); end
        busA.pc_in = 32'h0000_6000;
        busA.we = 1'b1; busA.addr_wr = 5'd12; busA.din = 32'h0;
        tick();
        busA.we = 1'b0;
        rdA(5'd12, rd);
        checks++; if (rd !== 32'h0000_0203) begin errors++; $display("[TB] FAIL sw_wr_dropped: got %h expected 00000203", rd); end
        rdA(5'd13, rd);
        checks++; if (rd !== 32'h0000_0200) begin errors++; $display("[TB] FAIL sw_cause: got %h expected 00000200", rd); end
        checks++; if (busA.epc !== 32'h0000_6000) begin errors++; $display("[TB] FAIL sw_epc: got %h expected 00006000", busA.epc); end
        wrA(5'd13, 32'h0);
        wrA(5'd12, 32'h0);
    endtask

    task automatic test_edge();
        busB.hw_int = 5'b00001;
        tick();
        busB.hw_int = 5'b00000;
        tick();
        rdB(5'd13, rd);
        checks++; if (rd !== 32'h0000_0400) begin errors++; $display("[TB] FAIL edge_latch: got %h expected 00000400", rd); end
        wrB(5'd13, 32'h0000_0400);
        rdB(5'd13, rd);
        checks++; if (rd !== 32'h0000_0400) begin errors++; $display("[TB] FAIL edge_wr1: got %h expected 00000400", rd); end
        wrB(5'd13, 32'h0);
        rdB(5'd13, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL edge_clear: got %h expected 00000000", rd); end
        busB.hw_int = 5'b00001;
        wrB(5'd13, 32'h0);
        busB.hw_int = 5'b00000;
        rdB(5'd13, rd);
        checks++; if (rd !== 32'h0000_0400) begin errors++; $display("[TB] FAIL edge_vs_clear: got %h expected 00000400", rd); end
        wrB(5'd13, 32'h0);
    endtask

    task automatic test_timer();
        wrB(5'd11, 32'd5);
        wrB(5'd9, 32'd0);
        rdB(5'd9, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("[TB] FAIL tmr_load: got %h expected 00000000", rd); end
        for (int k = 0; k < 4; k++) tick();
        rdB(5'd13, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL tmr_early: got %h expected 00000000", rd); end
        tick();
        rdB(5'd13, rd);
        checks++; if (rd !== 32'h0000_8000) begin errors++; $display("[TB] FAIL tmr_hit: got %h expected 00008000", rd); end
        rdB(5'd9, rd);
        checks++; if (rd !== 32'd5) begin errors++; $display("[TB] FAIL tmr_count: got %h expected 00000005", rd); end
        wrB(5'd11, 32'd20);
        rdB(5'd13, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL tmr_cmp_clr: got %h expected 00000000", rd); end
        wrB(5'd9, 32'hFFFF_FFFF);
        tick();
        rdB(5'd9, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL tmr_wrap: got %h expected 00000000", rd); end
        rdB(5'd13, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL tmr_spurious: got %h expected 00000000", rd); end
    endtask

    task automatic test_reset_mid();
        wrB(5'd12, 32'h0000_0401);
        busB.pc_in = 32'h0000_7000;
        busB.hw_int = 5'b00001;
        tick();
        busB.hw_int = 5'b00000;
        checks++; if (busB.int_req !== 1'b1) begin errors++; $display("[TB] FAIL mid_req: got %b expected 1", busB.int_req); end
        tick();
        rdB(5'd12, rd);
        checks++; if (rd !== 32'h0000_0403) begin errors++; $display("[TB] FAIL mid_exl: got %h expected 00000403", rd); end
        reset = 1'b0;
        busB.exc_code_in = 5'd3;
        #1;
        checks++; if (busB.int_req !== 1'b0) begin errors++; $display("[TB] FAIL mid_forced: got %b expected 0", busB.int_req); end
        tick();
        rdB(5'd12, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL mid_sr: got %h expected 00000000", rd); end
        rdB(5'd13, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL mid_cause: got %h expected 00000000", rd); end
        checks++; if (busB.epc !== 32'h0) begin errors++; $display("[TB] FAIL mid_epc: got %h expected 00000000", busB.epc); end
        rdB(5'd9, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL mid_count: got %h expected 00000000", rd); end
        rdB(5'd15, rd);
        checks++; if (rd !== 32'h2017_1204) begin errors++; $display("[TB] FAIL mid_prid: got %h expected 20171204", rd); end
        busB.exc_code_in = 5'd0;
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        busA.we = 1'b0; busA.addr_rd = 5'd0; busA.addr_wr = 5'd0; busA.din = 32'h0;
        busA.pc_in = 32'h0; busA.bd_in = 1'b0; busA.exc_code_in = 5'd0; busA.exl_clr = 1'b0;
        busA.hw_int = '0;
        busB.we = 1'b0; busB.addr_rd = 5'd0; busB.addr_wr = 5'd0; busB.din = 32'h0;
        busB.pc_in = 32'h0; busB.bd_in = 1'b0; busB.exc_code_in = 5'd0; busB.exl_clr = 1'b0;
        busB.hw_int = '0;
        test_reset();
        test_level();
        test_sync_exc();
        test_softint();
        test_edge();
        test_timer();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
